// File: rtl/wish_unpack.sv
// wish_unpack: splits one NUM_PACK*DATA_WIDTH Wishbone word into NUM_PACK narrow beats.
// Optional macro WISH_UNPACK_PREFETCH_EN adds a wide holding register so s_ack_o no longer depends on d_ack_i.
module wish_unpack #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    input  logic                           d_ack_i,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    output logic                           d_last_o
);

    localparam int W  = DATA_WIDTH * NUM_PACK;
    localparam int CW = $clog2(NUM_PACK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PACK - 1);

    typedef enum logic {EMPTY, DRAIN} state_e;

    state_e               state_q;
    logic [CW-1:0]        beatCnt_q;
    logic [W-1:0]         shiftBuf_q;
    logic [W-1:0]         shifted_d;
    logic [TGC_WIDTH-1:0] tag_q;

    logic beat;
    logic finalBeat;
    logic accept;
    logic loadSrc;

`ifdef WISH_UNPACK_PREFETCH_EN
    logic [W-1:0]         holdBuf_q;
    logic [TGC_WIDTH-1:0] holdTag_q;
    logic                 holdValid_q;
`endif

    assign beat      = (state_q == DRAIN) & d_ack_i;
    assign finalBeat = beat & (beatCnt_q == LAST_CNT);

`ifdef WISH_UNPACK_PREFETCH_EN
    assign s_ack_o = s_stb_i & s_cyc_i & !rst_i & !holdValid_q;
`else
    assign s_ack_o = s_stb_i & s_cyc_i & !rst_i & ((state_q == EMPTY) | finalBeat);
`endif

    assign s_stall_o = s_stb_i & s_cyc_i & !s_ack_o;
    assign accept    = s_ack_o;
    // A word goes straight into the shift buffer only when nothing is left to drain after this edge.
    assign loadSrc   = accept & ((state_q == EMPTY) | finalBeat);

    // The output end of the buffer is its low slice for little-endian and its high slice otherwise.
    generate
        if (LITTLE_ENDIAN != 0) begin : gLittle
            assign shifted_d = shiftBuf_q >> DATA_WIDTH;
            assign d_dat_o   = shiftBuf_q[DATA_WIDTH-1:0];
        end else begin : gBig
            assign shifted_d = shiftBuf_q << DATA_WIDTH;
            assign d_dat_o   = shiftBuf_q[W-1 -: DATA_WIDTH];
        end
    endgenerate

    assign d_stb_o  = (state_q == DRAIN);
    assign d_cyc_o  = d_stb_o;
    assign d_tgc_o  = tag_q;
    assign d_last_o = d_stb_o & (beatCnt_q == LAST_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            beatCnt_q  <= '0;
            shiftBuf_q <= '0;
            tag_q      <= '0;
        end else if (loadSrc) begin
            state_q    <= DRAIN;
            beatCnt_q  <= '0;
            shiftBuf_q <= s_dat_i;
            tag_q      <= s_tgc_i;
`ifdef WISH_UNPACK_PREFETCH_EN
        end else if (finalBeat && holdValid_q) begin
            state_q    <= DRAIN;
            beatCnt_q  <= '0;
            shiftBuf_q <= holdBuf_q;
            tag_q      <= holdTag_q;
`endif
        end else if (beat) begin
            shiftBuf_q <= shifted_d;
            if (finalBeat) begin
                state_q   <= EMPTY;
                beatCnt_q <= '0;
            end else begin
                beatCnt_q <= beatCnt_q + CW'(1);
            end
        end
    end

`ifdef WISH_UNPACK_PREFETCH_EN
    // Words accepted mid-drain park here until the final beat hands them to the shift buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            holdValid_q <= 1'b0;
            holdBuf_q   <= '0;
            holdTag_q   <= '0;
        end else if (accept && !loadSrc) begin
            holdValid_q <= 1'b1;
            holdBuf_q   <= s_dat_i;
            holdTag_q   <= s_tgc_i;
        end else if (finalBeat) begin
            holdValid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wish_unpack.sv
// tb_wish_unpack: directed checks of wish_unpack with little- and big-endian instances driven in lockstep.
// Prefetch-only expectations are enabled when WISH_UNPACK_PREFETCH_EN is defined.
module tb_wish_unpack;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int TW = 2;
`ifdef WISH_UNPACK_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b1;
    logic          s_stb_i = 1'b0;
    logic          s_cyc_i = 1'b0;
    logic [31:0]   s_dat_i = '0;
    logic [TW-1:0] s_tgc_i = '0;
    logic          d_ack_i = 1'b0;

    logic          leAck, leStall, leStb, leCyc, leLast;
    logic [DW-1:0] leDat;
    logic [TW-1:0] leTgc;
    logic          beAck, beStall, beStb, beCyc, beLast;
    logic [DW-1:0] beDat;
    logic [TW-1:0] beTgc;

    int checks = 0;
    int fails  = 0;

    logic [7:0] le1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] be1 [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    logic [7:0] le3 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] be3 [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    logic [7:0] le5 [4] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
    logic [7:0] be5 [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

    always #5 clk_i = ~clk_i;

    wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1)) dutLe (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(leAck), .s_stall_o(leStall),
        .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
        .d_stb_o(leStb), .d_cyc_o(leCyc), .d_ack_i(d_ack_i),
        .d_dat_o(leDat), .d_tgc_o(leTgc), .d_last_o(leLast)
    );

    wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(0)) dutBe (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(beAck), .s_stall_o(beStall),
        .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
        .d_stb_o(beStb), .d_cyc_o(beCyc), .d_ack_i(d_ack_i),
        .d_dat_o(beDat), .d_tgc_o(beTgc), .d_last_o(beLast)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic rst, input logic stb, input logic [31:0] dat,
                                 input logic [TW-1:0] tgc, input logic ack);
        @(negedge clk_i);
        rst_i   = rst;
        s_stb_i = stb;
        s_cyc_i = stb;
        s_dat_i = dat;
        s_tgc_i = tgc;
        d_ack_i = ack;
        #1;
    endtask

    task automatic expectBeat(input string tag, input logic [7:0] le, input logic [7:0] be,
                              input logic [TW-1:0] tgc, input logic last);
        checkOutput({tag, " stb"}, leStb, 1);
        checkOutput({tag, " cyc"}, leCyc, 1);
        checkOutput({tag, " beStb"}, beStb, 1);
        checkOutput({tag, " leDat"}, leDat, le);
        checkOutput({tag, " beDat"}, beDat, be);
        checkOutput({tag, " tgc"}, leTgc, tgc);
        checkOutput({tag, " beTgc"}, beTgc, tgc);
        checkOutput({tag, " leLast"}, leLast, last);
        checkOutput({tag, " beLast"}, beLast, last);
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, " stb"}, leStb, 0);
        checkOutput({tag, " cyc"}, leCyc, 0);
        checkOutput({tag, " beStb"}, beStb, 0);
        checkOutput({tag, " last"}, leLast, 0);
    endtask

    task automatic expectAck(input string tag, input logic ack);
        checkOutput({tag, " ack"}, leAck, ack);
        checkOutput({tag, " beAck"}, beAck, ack);
        checkOutput({tag, " stall"}, leStall, s_stb_i & ~ack);
    endtask

    initial begin
        logic pend;
        logic expAck;

        // Reset with a strobe pending: ack is forced low.
        applyStimulus(1, 1, 32'h12345678, 2'b11, 0);
        expectAck("rstAck", 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        expectIdle("reset");
        checkOutput("reset leDat", leDat, 0);
        checkOutput("reset beDat", beDat, 0);
        checkOutput("reset tgc", leTgc, 0);

        // Single word, both byte orders.
        applyStimulus(0, 1, 32'hDDCCBBAA, 2'b01, 1);
        expectAck("t1acc", 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            expectBeat($sformatf("t1b%0d", k), le1[k], be1[k], 2'b01, k == 3);
        end
        applyStimulus(0, 0, 0, 0, 1);
        expectIdle("t1end");

        // Back-to-back words with no bubble.
        applyStimulus(0, 1, 32'h44332211, 2'b10, 1);
        expectAck("t3accA", 1);
        pend = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, pend, 32'h88776655, 2'b11, 1);
            expectBeat($sformatf("t3b%0d", i), le3[i], be3[i], (i < 4) ? 2'b10 : 2'b11, (i == 3) || (i == 7));
            if (pend) begin
                expAck = PF ? 1'b1 : (i == 3);
                expectAck($sformatf("t3accB%0d", i), expAck);
                if (expAck) pend = 1'b0;
            end
        end
        applyStimulus(0, 0, 0, 0, 1);
        expectIdle("t3end");

        // Backpressure after beat BB, with a new word offered.
        applyStimulus(0, 1, 32'hDDCCBBAA, 2'b10, 1);
        expectAck("t4acc", 1);
        applyStimulus(0, 0, 0, 0, 1);
        expectBeat("t4b0", 8'hAA, 8'hDD, 2'b10, 0);
        pend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, pend, 32'h11223344, 2'b01, 0);
            expectBeat($sformatf("t4hold%0d", i), 8'hBB, 8'hCC, 2'b10, 0);
            if (pend) begin
                expAck = PF && (i == 0);
                expectAck($sformatf("t4stall%0d", i), expAck);
                if (expAck) pend = 1'b0;
            end
        end
        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            expectBeat($sformatf("t4b%0d", k), le1[k], be1[k], 2'b10, k == 3);
        end
`ifdef WISH_UNPACK_PREFETCH_EN
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            expectBeat($sformatf("t4h%0d", k), be3[k], le3[k], 2'b01, k == 3);
        end
`endif
        applyStimulus(0, 0, 0, 0, 1);
        expectIdle("t4end");

        // Reset mid-drain discards the remaining beats.
        applyStimulus(0, 1, 32'hDDCCBBAA, 2'b11, 1);
        expectAck("t5acc", 1);
        applyStimulus(0, 0, 0, 0, 1);
        expectBeat("t5b0", 8'hAA, 8'hDD, 2'b11, 0);
        applyStimulus(0, 0, 0, 0, 1);
        expectBeat("t5b1", 8'hBB, 8'hCC, 2'b11, 0);
        applyStimulus(1, 1, 32'h0A0B0C0D, 2'b00, 1);
        expectAck("t5rst", 0);
        applyStimulus(0, 1, 32'h0A0B0C0D, 2'b00, 1);
        expectIdle("t5idle");
        checkOutput("t5 leDat", leDat, 0);
        checkOutput("t5 beDat", beDat, 0);
        checkOutput("t5 tgc", leTgc, 0);
        expectAck("t5acc2", 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            expectBeat($sformatf("t5n%0d", k), le5[k], be5[k], 2'b00, k == 3);
        end
        applyStimulus(0, 0, 0, 0, 1);
        expectIdle("t5end");

`ifdef WISH_UNPACK_PREFETCH_EN
        // Prefetch: two words accepted while the sink stalls, the third is held off.
        applyStimulus(0, 1, 32'h44332211, 2'b01, 0);
        expectAck("t6accA", 1);
        applyStimulus(0, 1, 32'h88776655, 2'b10, 0);
        expectAck("t6accB", 1);
        expectBeat("t6w0", 8'h11, 8'h44, 2'b01, 0);
        applyStimulus(0, 1, 32'hCAFEBABE, 2'b11, 0);
        expectAck("t6stallC", 0);
        expectBeat("t6w1", 8'h11, 8'h44, 2'b01, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            expectBeat($sformatf("t6b%0d", i), le3[i], be3[i], (i < 4) ? 2'b01 : 2'b10, (i == 3) || (i == 7));
        end
        applyStimulus(0, 0, 0, 0, 1);
        expectIdle("t6end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
